pwm_cfg_sequencer: RTL and testbench
====================================

# pwm_cfg_sequencer

Wishbone master that programs one `pwm_timer` instance from a single-cycle configuration request. It captures a full register set (period, duty cycle, divisor, control) and issues the write sequence over the timer's Wishbone slave port, waiting for each acknowledge. The timer is stopped before being reprogrammed, so it never runs with a half-updated configuration. It sits between firmware or a host-side control FSM and the `pwm_timer` bus port.

## Interface
- `CTRL_RUN_MASK`, default 16'h0014: ctrl bits that start the timer (counter enable and output enable). These bits are cleared in the stop write.
- `ACK_TIMEOUT`, default 16: maximum number of cycles that stb may stay high without an ack before the sequence aborts. Legal range 1..65535.
- `i_clk`  in  1: system clock; all logic is on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous assert, active-low.
- `i_start`  in  1: configuration request. Sampled only in IDLE.
- `i_quick`  in  1: when 1 at start, the stop write is skipped. Latched with the request.
- `i_period`, `i_dc`, `i_divisor`, `i_ctrl`  in  16 each: register values. Latched on the accepted start.
- `o_busy`  out  1: high while a sequence is in progress.
- `o_done`  out  1: one-cycle pulse at the end of a sequence, whether it completed or aborted.
- `o_err`  out  1: high only in the `o_done` cycle, and only when the sequence aborted on timeout.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each: Wishbone master controls. cyc and stb are always equal. we is 1 whenever stb is 1.
- `o_wb_adr`  out  4: register address (ctrl = 0, divisor = 1, period = 2, dc = 3).
- `o_wb_data`  out  16: write data.
- `i_wb_ack`  in  1: slave acknowledge.

## Operation
- States: IDLE, STOP, PER, DC, DIV, CTRL, DONE.
- IDLE: when `i_start` = 1, latch all inputs and go to STOP. If latched quick = 1, go to PER instead.
- Write order and content:
  - STOP: adr 0, data = `ctrl & ~CTRL_RUN_MASK`.
  - PER: adr 2, data = period.
  - DC: adr 3, data = dc.
  - DIV: adr 1, data = divisor.
  - CTRL: adr 0, data = ctrl.
- The full ctrl value is written last, so the timer restarts only once all other registers are loaded.
- Each write state has two phases:
  - Setup: one cycle with cyc/stb = 0. adr and data are driven with that state's values.
  - Strobe: cyc/stb/we = 1, with adr and data held stable, until `i_wb_ack` = 1 is sampled at a rising edge.
  - On the ack edge, advance to the next state's setup phase. After CTRL, advance to DONE.
- `i_wb_ack` sampled while stb = 0 is ignored.
- Timeout:
  - A counter clears at the start of each strobe phase and increments every strobe cycle without ack.
  - When the counter reaches `ACK_TIMEOUT` with no ack, drop cyc/stb at the next edge, go to DONE, and set the error flag.
  - Registers already written stay written. No retry is attempted.
- DONE: lasts one cycle. `o_done` = 1, `o_err` = error flag, then return to IDLE and clear the error flag.
- `i_start` asserted in any state other than IDLE is ignored and is not queued.

## Timing
- Reset values of all outputs:
  - `o_busy`, `o_done`, `o_err`, `o_wb_cyc`, `o_wb_stb`, `o_wb_we` = 0.
  - `o_wb_adr` = 0, `o_wb_data` = 0.
- Asserting `i_rst_n` mid-transaction drops cyc/stb immediately (asynchronously) and returns the FSM to IDLE. The partial sequence is abandoned.
- `o_busy` rises on the edge that accepts `i_start` and falls on the edge that leaves DONE. It is therefore 1 during the `o_done` cycle.
- Latency, counting the start-accept edge as edge 0 and using a zero-wait slave (ack in the first strobe cycle):
  - Full sequence: 5 writes × 2 cycles. `o_done` is high in cycle 11; `o_busy` is high for 11 cycles.
  - Quick sequence: `o_done` is high in cycle 9.
- Each ack wait state adds one cycle.
- Timeout abort: stb is high for exactly `ACK_TIMEOUT` cycles. `o_done`/`o_err` are high in the cycle after stb drops.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Zero-wait slave, start with period 100, dc 40, divisor 4, ctrl 16'h0016, quick 0:
  - Bus writes in order: (0, 16'h0002), (2, 100), (3, 40), (1, 4), (0, 16'h0016).
  - cyc is low for exactly one cycle between writes.
  - `o_done` pulses in cycle 11 with `o_err` = 0.
- Slave acks after 3 wait cycles on every write, quick 1:
  - Exactly four writes, with adr/data stable throughout each strobe.
  - `o_done` arrives at cycle 9 + 4×3 = 21.
- Slave never acks the DC write, `ACK_TIMEOUT` = 16:
  - stb is high for exactly 16 cycles at adr 3, then drops.
  - `o_done` and `o_err` are both 1 for one cycle. No DIV or CTRL write is issued.
- `i_start` pulsed again during PER with different data:
  - Ignored. The bus carries only the first request's values.
  - One `o_done`. The FSM accepts a new start the cycle after DONE.
- `i_rst_n` pulled low during the strobe of the DIV write:
  - cyc, stb, `o_busy` are 0 before the next clock edge.
  - After release, the block stays in IDLE with all outputs 0 until the next start.
- Back-to-back: `i_start` held high continuously:
  - A new sequence starts on the edge that returns to IDLE.
  - `o_done` pulses are separated by 12 cycles with a zero-wait slave.

Source files
------------

// File: rtl/pwm_cfg_sequencer.sv
// Wishbone master that loads a pwm_timer register set: optional stop write,
// then period, duty cycle, divisor and finally the full ctrl word.
module pwm_cfg_sequencer #(
  parameter logic [15:0] CTRL_RUN_MASK = 16'h0014,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_quick,
  input  logic [15:0] i_period,
  input  logic [15:0] i_dc,
  input  logic [15:0] i_divisor,
  input  logic [15:0] i_ctrl,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_adr,
  output logic [15:0] o_wb_data,
  input  logic        i_wb_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_STOP, S_PER, S_DC, S_DIV, S_CTRL, S_DONE
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        strobe_reg, strobe_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        err_flag_reg, err_flag_next;
  logic [15:0] period_reg, period_next;
  logic [15:0] dc_reg, dc_next;
  logic [15:0] div_reg, div_next;
  logic [15:0] ctrl_reg, ctrl_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_out_reg, err_out_next;
  logic [3:0]  adr_reg, adr_next;
  logic [15:0] data_reg, data_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= S_IDLE;
      strobe_reg   <= 1'b0;
      cnt_reg      <= '0;
      err_flag_reg <= 1'b0;
      period_reg   <= '0;
      dc_reg       <= '0;
      div_reg      <= '0;
      ctrl_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_out_reg  <= 1'b0;
      adr_reg      <= '0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      strobe_reg   <= strobe_next;
      cnt_reg      <= cnt_next;
      err_flag_reg <= err_flag_next;
      period_reg   <= period_next;
      dc_reg       <= dc_next;
      div_reg      <= div_next;
      ctrl_reg     <= ctrl_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_out_reg  <= err_out_next;
      adr_reg      <= adr_next;
      data_reg     <= data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    strobe_next   = strobe_reg;
    cnt_next      = cnt_reg;
    err_flag_next = err_flag_reg;
    period_next   = period_reg;
    dc_next       = dc_reg;
    div_next      = div_reg;
    ctrl_next     = ctrl_reg;
    adr_next      = adr_reg;
    data_next     = data_reg;

    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          period_next   = i_period;
          dc_next       = i_dc;
          div_next      = i_divisor;
          ctrl_next     = i_ctrl;
          err_flag_next = 1'b0;
          state_next    = i_quick ? S_PER : S_STOP;
        end
      end
      S_DONE: begin
        state_next    = S_IDLE;
        err_flag_next = 1'b0;
      end
      default: begin
        // Write states: one setup cycle, then strobe until ack or timeout
        if (!strobe_reg) begin
          strobe_next = 1'b1;
          cnt_next    = '0;
        end else if (i_wb_ack) begin
          strobe_next = 1'b0;
          case (state_reg)
            S_STOP:  state_next = S_PER;
            S_PER:   state_next = S_DC;
            S_DC:    state_next = S_DIV;
            S_DIV:   state_next = S_CTRL;
            default: state_next = S_DONE;
          endcase
        end else if (cnt_reg == CNT_LAST) begin
          strobe_next   = 1'b0;
          state_next    = S_DONE;
          err_flag_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
    endcase

    // Address/data are computed from the next state so they are stable
    // from the setup cycle through the whole strobe.
    case (state_next)
      S_STOP: begin adr_next = 4'd0; data_next = ctrl_next & ~CTRL_RUN_MASK; end
      S_PER:  begin adr_next = 4'd2; data_next = period_next; end
      S_DC:   begin adr_next = 4'd3; data_next = dc_next; end
      S_DIV:  begin adr_next = 4'd1; data_next = div_next; end
      S_CTRL: begin adr_next = 4'd0; data_next = ctrl_next; end
      default: ;
    endcase

    busy_next    = (state_next != S_IDLE);
    done_next    = (state_next == S_DONE);
    err_out_next = done_next && err_flag_next;
  end

  assign o_busy    = busy_reg;
  assign o_done    = done_reg;
  assign o_err     = err_out_reg;
  assign o_wb_cyc  = strobe_reg;
  assign o_wb_stb  = strobe_reg;
  assign o_wb_we   = strobe_reg;
  assign o_wb_adr  = adr_reg;
  assign o_wb_data = data_reg;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Scoreboard bench for pwm_cfg_sequencer: expected writes and done events are
// queued by the stimulus and checked by an independent bus monitor.
module tb_pwm_cfg_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_quick = 1'b0;
  logic [15:0] i_period = '0, i_dc = '0, i_divisor = '0, i_ctrl = '0;
  logic        i_wb_ack = 1'b0;
  logic        o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_adr;
  logic [15:0] o_wb_data;

  pwm_cfg_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_quick(i_quick),
    .i_period(i_period), .i_dc(i_dc), .i_divisor(i_divisor), .i_ctrl(i_ctrl),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [3:0] adr; logic [15:0] data; } wr_t;
  typedef struct { logic err; int cyc; int blen; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  total = 0, bad = 0;
  int  cycle_num = 0;

  // slave behaviour knobs
  int  wait_n = 0;
  int  no_ack_adr = -1;
  bit  spurious = 0;

  // monitor state
  bit          prev_stb = 0, ack_seen = 0;
  int          run = 0, last_run = 0, gap = 0, busy_run = 0;
  logic [3:0]  s_adr = '0, last_adr = '0;
  logic [15:0] s_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    cycle_num++;
  end

  // Wishbone slave: ack after wait_n strobe cycles, optional stuck address
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_wb_stb && int'(o_wb_adr) != no_ack_adr) begin
        i_wb_ack = (wcnt == wait_n);
        wcnt++;
      end else begin
        i_wb_ack = spurious && o_busy && !o_wb_stb;
        wcnt = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      prev_stb = 0; ack_seen = 0; busy_run = 0;
    end else begin
      chk("cyc_eq_stb", o_wb_cyc, o_wb_stb);
      chk("err_only_with_done", o_err, o_err & o_done);
      if (o_busy) busy_run++; else busy_run = 0;
      if (o_wb_stb) begin
        if (!prev_stb) begin
          s_adr = o_wb_adr; s_data = o_wb_data; run = 0;
          if (ack_seen) chk("setup_gap", gap, 1);
        end
        run++;
        chk("we_high", o_wb_we, 1);
        chk("adr_stable", o_wb_adr, s_adr);
        chk("data_stable", o_wb_data, s_data);
        if (i_wb_ack) begin
          if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write actual adr=%0d data=%04h required=none", o_wb_adr, o_wb_data);
          end else begin
            wr_t w;
            w = wq.pop_front();
            $display("write adr=%0d data=%04h cycle=%0d", o_wb_adr, o_wb_data, cycle_num);
            chk("write_adr", o_wb_adr, w.adr);
            chk("write_data", o_wb_data, w.data);
          end
          ack_seen = 1; gap = 0;
        end
      end else begin
        if (prev_stb) begin last_run = run; last_adr = s_adr; end
        if (ack_seen) gap++;
      end
      if (o_done) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done actual cycle=%0d required=none", cycle_num);
        end else begin
          dn_t d;
          d = dq.pop_front();
          $display("done err=%0d cycle=%0d busy_len=%0d", o_err, cycle_num, busy_run);
          chk("done_err", o_err, d.err);
          chk("done_cycle", cycle_num, d.cyc);
          chk("busy_len", busy_run, d.blen);
          if (d.err) begin
            chk("timeout_stb_len", last_run, 16);
            chk("timeout_adr", last_adr, 3);
          end
        end
        ack_seen = 0;
      end
      prev_stb = o_wb_stb;
    end
  end

  task automatic drive(input logic q, input logic [15:0] per, dc, dv, ct);
    i_quick = q; i_period = per; i_dc = dc; i_divisor = dv; i_ctrl = ct;
  endtask

  task automatic pulse_start(output int acc);
    @(negedge i_clk);
    i_start = 1'b1;
    acc = cycle_num + 1;
    @(negedge i_clk);
    i_start = 1'b0;
    drive(1'b0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [15:0] d);
    wr_t w;
    w.adr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic push_done(input logic e, input int c, input int bl);
    dn_t d;
    d.err = e; d.cyc = c; d.blen = bl;
    dq.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge i_clk);
      #1;
      if (wq.size() == 0 && dq.size() == 0 && !o_busy) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_timeout actual wq=%0d dq=%0d required=0", name, wq.size(), dq.size());
      wq.delete(); dq.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, o_busy, 0);
    chk({name, "_done"}, o_done, 0);
    chk({name, "_err"}, o_err, 0);
    chk({name, "_cyc"}, o_wb_cyc, 0);
    chk({name, "_stb"}, o_wb_stb, 0);
    chk({name, "_we"}, o_wb_we, 0);
    chk({name, "_adr"}, o_wb_adr, 0);
    chk({name, "_data"}, o_wb_data, 0);
  endtask

  initial begin
    int acc;
    // reset state
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    chk_all_zero("post_reset");

    // full sequence, zero-wait slave
    push_wr(4'd0, 16'h0002); push_wr(4'd2, 16'd100); push_wr(4'd3, 16'd40);
    push_wr(4'd1, 16'd4);    push_wr(4'd0, 16'h0016);
    drive(1'b0, 16'd100, 16'd40, 16'd4, 16'h0016);
    pulse_start(acc);
    push_done(1'b0, acc + 10, 11);
    wait_idle("full");

    // quick sequence, 3 wait states, ack asserted during setup cycles
    wait_n = 3; spurious = 1;
    push_wr(4'd2, 16'h1234); push_wr(4'd3, 16'h0567);
    push_wr(4'd1, 16'h0009); push_wr(4'd0, 16'h00F5);
    drive(1'b1, 16'h1234, 16'h0567, 16'h0009, 16'h00F5);
    pulse_start(acc);
    push_done(1'b0, acc + 20, 21);
    wait_idle("quick_wait");
    wait_n = 0; spurious = 0;

    // DC write never acked: timeout abort
    no_ack_adr = 3;
    push_wr(4'd0, 16'h0008); push_wr(4'd2, 16'd500);
    drive(1'b0, 16'd500, 16'd250, 16'd2, 16'h001C);
    pulse_start(acc);
    push_done(1'b1, acc + 21, 22);
    wait_idle("timeout");
    no_ack_adr = -1;

    // second start during PER is ignored
    push_wr(4'd0, 16'hFFEB); push_wr(4'd2, 16'd7); push_wr(4'd3, 16'd3);
    push_wr(4'd1, 16'd1);    push_wr(4'd0, 16'hFFFF);
    drive(1'b0, 16'd7, 16'd3, 16'd1, 16'hFFFF);
    pulse_start(acc);
    push_done(1'b0, acc + 10, 11);
    repeat (2) @(negedge i_clk);
    drive(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_idle("ignored_start");

    // reset asserted during the DIV strobe
    wait_n = 2;
    push_wr(4'd0, 16'h0000); push_wr(4'd2, 16'd9); push_wr(4'd3, 16'd8);
    drive(1'b0, 16'd9, 16'd8, 16'd5, 16'h0004);
    pulse_start(acc);
    repeat (14) @(posedge i_clk);
    #2;
    chk("div_strobe_before_reset", o_wb_stb, 1);
    chk("div_adr_before_reset", o_wb_adr, 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_busy", o_busy, 0);
    chk("wq_empty_at_reset", wq.size(), 0);
    wq.delete(); dq.delete();
    wait_n = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk_all_zero("idle_after_rst");
    end

    // back-to-back with start held high
    for (int k = 0; k < 2; k++) begin
      push_wr(4'd0, 16'h0000); push_wr(4'd2, 16'd50); push_wr(4'd3, 16'd25);
      push_wr(4'd1, 16'd3);    push_wr(4'd0, 16'h0014);
    end
    drive(1'b0, 16'd50, 16'd25, 16'd3, 16'h0014);
    @(negedge i_clk);
    i_start = 1'b1;
    acc = cycle_num + 1;
    push_done(1'b0, acc + 10, 11);
    push_done(1'b0, acc + 22, 11);
    while (cycle_num < acc + 12) @(negedge i_clk);
    i_start = 1'b0;
    wait_idle("back_to_back");

    repeat (3) @(negedge i_clk);
    chk("final_wq_empty", wq.size(), 0);
    chk("final_dq_empty", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
